lc3_mem_responder: RTL and testbench
====================================

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 8, which is the processor address width.
REQ-002 The module SHALL have parameter IO_ADDR, default all-ones over ADDRESS_WIDTH, which is the memory-mapped console address.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock, with all logic on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, the reset, synchronous and active-high.
REQ-005 The module SHALL have port address, input, ADDRESS_WIDTH bits, the processor access address.
REQ-006 The module SHALL have port data_in, input, 8 bits, the processor write data.
REQ-007 The module SHALL have port write, input, 1 bit, where 1 means write this cycle and 0 means read.
REQ-008 The module SHALL have port data_out, output, 8 bits, the registered read data returned to the processor.
REQ-009 The module SHALL have port con_valid, output, 1 bit, meaning the console byte is valid.
REQ-010 The module SHALL have port con_data, output, 8 bits, the console byte (head of the FIFO).
REQ-011 The module SHALL have port con_ready, input, 1 bit, meaning the console sink accepts the byte.
REQ-012 The module SHALL have port wr_count, output, 16 bits, a saturating count of accepted RAM writes.

Function
REQ-013 RAM SHALL be 2^ADDRESS_WIDTH x 8 bits, with IO_ADDR excluded from RAM storage.
REQ-014 Read latency SHALL be 1 cycle: data_out after edge N equals mem[address] sampled at edge N.
REQ-015 On write=1 with address != IO_ADDR, mem[address] SHALL take data_in at the edge, and data_out SHALL take data_in (write-first).
REQ-016 On write=1 with address == IO_ADDR, data_in SHALL be pushed to the console FIFO, RAM SHALL be unchanged, and data_out SHALL load the status byte.
REQ-017 A read of IO_ADDR SHALL return the status byte {5'b0, ovf, count[1:0]}, where count is FIFO occupancy 0..2, sampled before that edge's push/pop.
REQ-018 The console FIFO SHALL be 2 entries deep, first-in first-out.
REQ-019 con_valid SHALL be 1 exactly when count > 0, and con_data SHALL be the oldest entry.
REQ-020 A pop SHALL occur at an edge where con_valid and con_ready are both 1.
REQ-021 Once asserted, con_valid and con_data SHALL remain stable until popped.
REQ-022 A push while full without a same-edge pop SHALL drop the byte and set the sticky flag ovf.
REQ-023 A push while full with a same-edge pop SHALL be accepted, leaving count at 2 and ovf unchanged.
REQ-024 A push while empty with con_ready=1 SHALL NOT bypass the FIFO: con_valid rises the next cycle.
REQ-025 ovf SHALL clear only on rst.
REQ-026 wr_count SHALL increment on each RAM write (not IO writes) and saturate at 0xFFFF.
REQ-027 Address wrap-around SHALL be natural modulo 2^ADDRESS_WIDTH, with no out-of-range case.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set data_out=0, FIFO count=0, con_valid=0, con_data=0, ovf=0, and wr_count=0.
REQ-029 RAM contents SHALL NOT be reset, and a write presented with rst=1 SHALL be ignored.
REQ-030 Reset during a pending console byte SHALL discard it, and con_valid SHALL be 0 the next cycle regardless of con_ready.

Structure
REQ-031 Package lc3_mem_pkg SHALL hold the FIFO depth constant (2), the status bit positions (OVF_BIT=2, CNT_LSB=0), and the wr_count width (16).
REQ-032 One sub-module, lc3_io_fifo (2-entry FIFO with push, pop, count, and ovf), SHALL be instantiated once, and the RAM and read register SHALL stay in the top module.

Verification
REQ-033 The bench SHALL write 0x5A to 0x10, then read 0x10 on the next cycle, and require data_out=0x5A one cycle after the read.
REQ-034 The bench SHALL write 0x33 to 0x20, then hold address 0x20 with write=1 and data 0x44, and require data_out=0x44 after that edge.
REQ-035 The bench SHALL, with con_ready=0, write 0x41, 0x42, and 0x43 to IO_ADDR, then read IO_ADDR, and require status=0x06 (ovf=1, count=2) and con_data=0x41.
REQ-036 The bench SHALL, from the full state, write 0x44 to IO_ADDR with con_ready=1, and require the next cycle con_data=0x42, count=2, and ovf unchanged, and the pop order 0x42 then 0x44.
REQ-037 The bench SHALL perform 70000 RAM writes and require wr_count=0xFFFF, and SHALL require that IO writes do not change wr_count.
REQ-038 The bench SHALL assert rst for 1 cycle with con_valid=1 and ovf=1, and require the next cycle con_valid=0, data_out=0, wr_count=0, and status read=0x00.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared constants for the LC-3 memory responder and its console FIFO
package lc3_mem_pkg;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;
  localparam int OVF_BIT = 2;
  localparam int CNT_LSB = 0;
  localparam int WR_COUNT_W = 16;
endpackage

// File: rtl/lc3_io_fifo.sv
// lc3_io_fifo: 2-entry console FIFO with sticky overflow flag
module lc3_io_fifo
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] head,
  output logic [1:0] count,
  output logic       ovf
);
  logic [7:0] m0, m1;
  logic pop, acc;
  assign valid = count != 2'd0;
  assign head = m0;
  assign pop = valid & ready;
  assign acc = push & ((count != FIFO_DEPTH) | pop);
  always_ff @(posedge clk)
    if (rst) begin
      count <= 2'd0;
      m0 <= 8'd0;
      m1 <= 8'd0;
      ovf <= 1'b0;
    end else begin
      count <= count + {1'b0, acc} - {1'b0, pop};
      ovf <= ovf | (push & ~acc);
      if (pop) m0 <= (count == FIFO_DEPTH) ? m1 : push_data;
      else if (acc && count == 2'd0) m0 <= push_data;
      if (acc && (count == FIFO_DEPTH || (count == 2'd1 && !pop))) m1 <= push_data;
    end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: LC-3 RAM with registered read, memory-mapped console FIFO and write counter
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter logic [ADDRESS_WIDTH-1:0] IO_ADDR = {ADDRESS_WIDTH{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [7:0]               data_in,
  input  logic                     write,
  output logic [7:0]               data_out,
  output logic                     con_valid,
  output logic [7:0]               con_data,
  input  logic                     con_ready,
  output logic [WR_COUNT_W-1:0]    wr_count
);
  logic [7:0] mem [0:(1<<ADDRESS_WIDTH)-1];
  logic [7:0] status;
  logic [1:0] count;
  logic ovf, is_io, ram_wr, io_wr;
  assign is_io = address == IO_ADDR;
  assign ram_wr = write & ~is_io & ~rst;
  assign io_wr = write & is_io & ~rst;
  always_comb begin
    status = 8'd0;
    status[OVF_BIT] = ovf;
    status[CNT_LSB +: 2] = count;
  end
  always_ff @(posedge clk)
    if (ram_wr) mem[address] <= data_in;
  always_ff @(posedge clk)
    if (rst) begin
      data_out <= 8'd0;
      wr_count <= '0;
    end else begin
      data_out <= is_io ? status : write ? data_in : mem[address];
      if (ram_wr && wr_count != {WR_COUNT_W{1'b1}}) wr_count <= wr_count + 1'b1;
    end
  lc3_io_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(io_wr),
    .push_data(data_in),
    .ready(con_ready),
    .valid(con_valid),
    .head(con_data),
    .count(count),
    .ovf(ovf)
  );
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed self-checking bench for lc3_mem_responder
module tb_lc3_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] address = 8'd0;
  logic [7:0] data_in = 8'd0;
  logic write = 1'b0;
  logic con_ready = 1'b0;
  logic [7:0] data_out, con_data;
  logic con_valid;
  logic [15:0] wr_count;
  int n_cmp = 0;
  int n_bad = 0;
  lc3_mem_responder dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .data_in(data_in),
    .write(write),
    .data_out(data_out),
    .con_valid(con_valid),
    .con_data(con_data),
    .con_ready(con_ready),
    .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
    address = a;
    data_in = d;
    write = w;
    @(negedge clk);
  endtask
  initial begin
    cyc(8'h00, 8'h00, 1'b0);
    cyc(8'h00, 8'h00, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_valid", con_valid, 1'b0);
    chk("rst_cdata", con_data, 8'h00);
    chk("rst_wrcnt", wr_count, 16'h0000);
    rst = 1'b0;
    cyc(8'h10, 8'h5A, 1'b1);
    chk("wr_first", data_out, 8'h5A);
    cyc(8'h10, 8'h00, 1'b0);
    chk("rd_10", data_out, 8'h5A);
    cyc(8'h20, 8'h33, 1'b1);
    cyc(8'h20, 8'h44, 1'b1);
    chk("wr_wr_20", data_out, 8'h44);
    cyc(8'h20, 8'h00, 1'b0);
    chk("rd_20", data_out, 8'h44);
    cyc(8'h00, 8'h11, 1'b1);
    cyc(8'hFE, 8'h77, 1'b1);
    cyc(8'h00, 8'h00, 1'b0);
    chk("rd_00", data_out, 8'h11);
    cyc(8'hFE, 8'h00, 1'b0);
    chk("rd_fe", data_out, 8'h77);
    cyc(8'h10, 8'h00, 1'b0);
    chk("rd_10_again", data_out, 8'h5A);
    chk("wrcnt_5", wr_count, 16'd5);
    cyc(8'hFF, 8'h41, 1'b1);
    chk("io1_status", data_out, 8'h00);
    chk("io1_valid", con_valid, 1'b1);
    chk("io1_cdata", con_data, 8'h41);
    cyc(8'hFF, 8'h42, 1'b1);
    chk("io2_status", data_out, 8'h01);
    cyc(8'hFF, 8'h43, 1'b1);
    chk("io3_status", data_out, 8'h02);
    cyc(8'hFF, 8'h00, 1'b0);
    chk("ovf_status", data_out, 8'h06);
    chk("ovf_cdata", con_data, 8'h41);
    chk("io_no_wrcnt", wr_count, 16'd5);
    con_ready = 1'b1;
    cyc(8'hFF, 8'h44, 1'b1);
    chk("full_pp_status", data_out, 8'h06);
    chk("full_pp_cdata", con_data, 8'h42);
    con_ready = 1'b0;
    cyc(8'hFF, 8'h00, 1'b0);
    chk("full_pp_cnt", data_out, 8'h06);
    chk("hold_cdata", con_data, 8'h42);
    con_ready = 1'b1;
    cyc(8'h10, 8'h00, 1'b0);
    chk("pop2_cdata", con_data, 8'h44);
    chk("pop2_valid", con_valid, 1'b1);
    cyc(8'h10, 8'h00, 1'b0);
    chk("pop3_valid", con_valid, 1'b0);
    cyc(8'hFF, 8'h55, 1'b1);
    chk("nobypass_valid", con_valid, 1'b1);
    chk("nobypass_cdata", con_data, 8'h55);
    cyc(8'h10, 8'h00, 1'b0);
    chk("nobypass_pop", con_valid, 1'b0);
    con_ready = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      logic [7:0] a;
      a = 8'(i % 255);
      cyc(a, a ^ 8'hA5, 1'b1);
    end
    chk("wrcnt_sat", wr_count, 16'hFFFF);
    cyc(8'hFF, 8'h66, 1'b1);
    chk("wrcnt_io_sat", wr_count, 16'hFFFF);
    cyc(8'hFF, 8'h00, 1'b0);
    chk("pre_rst_status", data_out, 8'h05);
    chk("pre_rst_valid", con_valid, 1'b1);
    rst = 1'b1;
    con_ready = 1'b1;
    cyc(8'h10, 8'hEE, 1'b1);
    rst = 1'b0;
    con_ready = 1'b0;
    chk("post_rst_valid", con_valid, 1'b0);
    chk("post_rst_dout", data_out, 8'h00);
    chk("post_rst_wrcnt", wr_count, 16'h0000);
    chk("post_rst_cdata", con_data, 8'h00);
    cyc(8'hFF, 8'h00, 1'b0);
    chk("post_rst_status", data_out, 8'h00);
    cyc(8'h10, 8'h00, 1'b0);
    chk("rst_wr_ignored", data_out, 8'hB5);
    chk("rst_wr_nocnt", wr_count, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
